// File: rtl/hs_pkg.sv
// Shared definitions for the 4-phase req/ack bundled-data CDC handshake.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hs_pkg;

    // Handshake FSM state, 1-bit encoding; shared with the source-side transmitter.
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } hs_state_t;

    // Fewest synchroniser flops that still give a usable MTBF.
    localparam int HS_SYNC_MIN = 2;

endpackage

// File: rtl/hs_sync_ff.sv
// N-flop level synchroniser for a single asynchronous control bit.
// Latency: N clk edges from din change to dout change.
// Backpressure: none; a level is passed through unconditionally.
module hs_sync_ff
    import hs_pkg::*;
#(
    parameter int N = HS_SYNC_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [N-1:0] stages;

    // Shift the asynchronous level through the flop chain; first stage may go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else begin
            stages <= {stages[N-2:0], din};
        end
    end

    assign dout = stages[N-1];

endmodule

// File: rtl/hs_rx_responder.sv
// Destination end of the 4-phase req/ack CDC handshake: sync req, capture word, ack, emit valid/ready.
// Latency: req_i rise to ack_o/out_valid_o high is SYNC_STAGES+1 edges; req_i fall to ack_o low likewise.
// Backpressure: ack is withheld while the output register holds an unaccepted word. Option: HS_RX_PARITY_EN.
module hs_rx_responder
    import hs_pkg::*;
#(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    input  logic [DW-1:0] data_i,
    output logic          ack_o,
    output logic          out_valid_o,
    output logic [DW-1:0] out_data_o,
    input  logic          out_ready_i,
`ifdef HS_RX_PARITY_EN
    input  logic          par_i,
    output logic          par_err_o,
`endif
    output logic          busy_o
);

    hs_state_t state;
    hs_state_t state_nxt;
    logic      req_s;
    logic      slot_free;
    logic      capture;
    logic      ack_nxt;

    // Only the request level crosses through flops; data_i is held stable by the protocol.
    hs_sync_ff #(
        .N (SYNC_STAGES)
    ) u_req_sync (
        .clk  (clk_i),
        .rst  (rst_i),
        .din  (req_i),
        .dout (req_s)
    );

    // The output register can take a new word if empty or being drained this cycle.
    assign slot_free = !out_valid_o || out_ready_i;

    // Next-state and capture decision; a new request is only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (req_s && slot_free) begin
                    capture   = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                ack_nxt = 1'b1;
                if (!req_s) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake state and registered acknowledge back to the source domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            ack_o <= 1'b0;
        end else begin
            state <= state_nxt;
            ack_o <= ack_nxt;
        end
    end

    // Output register: a capture wins over a concurrent accept so no word is lost.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
        end else if (capture) begin
            out_valid_o <= 1'b1;
            out_data_o  <= data_i;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

`ifdef HS_RX_PARITY_EN
    // One-cycle error flag aligned with the captured word; the word is still delivered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_err_o <= 1'b0;
        end else begin
            par_err_o <= capture && (^{data_i, par_i});
        end
    end
`endif

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_hs_rx_responder.sv
module tb_hs_rx_responder;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 1;

    logic          clk;
    logic          rst;
    logic          req;
    logic [DW-1:0] data;
    logic          ack;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
`ifdef HS_RX_PARITY_EN
    logic          par;
    logic          par_err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    hs_rx_responder #(
        .DW          (DW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .data_i      (data),
        .ack_o       (ack),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
`ifdef HS_RX_PARITY_EN
        .par_i       (par),
        .par_err_o   (par_err),
`endif
        .busy_o      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    // Drive the data word (and matching or deliberately wrong parity).
    task automatic set_word(input logic [DW-1:0] w, input logic bad_par);
        data = w;
`ifdef HS_RX_PARITY_EN
        par = (^w) ^ bad_par;
`endif
    endtask

    // Wait (bounded) for ack to reach lvl; n returns the number of clk edges taken.
    task automatic wait_ack(input logic lvl, input int max, output int n);
        n = 0;
        while (ack !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req       = 1'b0;
        out_ready = 1'b0;
        set_word('0, 1'b0);
        repeat (3) @(negedge clk);
        vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", ack); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 00", out_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef HS_RX_PARITY_EN
        vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL reset_par_err: got %b want 0", par_err); end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) w = 8'hA5;
            else        w = DW'($urandom_range(0, 255));
            set_word(w, 1'b0);
            req = 1'b1;
            wait_ack(1'b1, 20, n);
            vectors++; if (n != LAT) begin miscompares++; $display("FAIL single_rise_lat[%0d]: got %0d edges want %0d", i, n, LAT); end
            vectors++; if (out_valid !== 1'b1 || out_data !== w) begin
                miscompares++; $display("FAIL single_word[%0d]: got valid=%b data=%h want valid=1 data=%h", i, out_valid, out_data, w);
            end
`ifdef HS_RX_PARITY_EN
            vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL single_par_err[%0d]: got %b want 0", i, par_err); end
`endif
            req = 1'b0;
            wait_ack(1'b0, 20, n);
            vectors++; if (n != LAT) begin miscompares++; $display("FAIL single_fall_lat[%0d]: got %0d edges want %0d", i, n, LAT); end
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drained[%0d]: got valid=%b want 0", i, out_valid); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int  n;
        logic held_ok;
        out_ready = 1'b0;
        set_word(8'h11, 1'b0);
        req = 1'b1;
        wait_ack(1'b1, 20, n);
        req = 1'b0;
        wait_ack(1'b0, 20, n);
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            miscompares++; $display("FAIL bp_first_word: got valid=%b data=%h want valid=1 data=11", out_valid, out_data);
        end
        set_word(8'h22, 1'b0);
        req     = 1'b1;
        held_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ack !== 1'b0 || out_data !== 8'h11 || out_valid !== 1'b1) held_ok = 1'b0;
        end
        vectors++; if (!held_ok) begin
            miscompares++; $display("FAIL bp_stall: got ack=%b data=%h want ack=0 data=11 held", ack, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++; if (out_data !== 8'h22 || out_valid !== 1'b1 || ack !== 1'b1) begin
            miscompares++; $display("FAIL bp_release: got data=%h valid=%b ack=%b want data=22 valid=1 ack=1", out_data, out_valid, ack);
        end
        req = 1'b0;
        wait_ack(1'b0, 20, n);
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got valid=%b want 0", out_valid); end
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [DW-1:0] exp_q[$];
        int idx   = 0;
        int phase = 0;
        int got   = 0;
        int cyc   = 0;
        int req_hi = 0;
        logic prev_ack = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(DW'(i));
        while (!(got == 16 && idx == 16 && phase == 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            // req must have been seen high on at least LAT edges before ack may rise
            if (req) req_hi++; else req_hi = 0;
            if (ack && !prev_ack) begin
                vectors++;
                if (req_hi < LAT) begin
                    miscompares++; $display("FAIL stream_ack_early: ack rose after %0d req-high edges, need >= %0d", req_hi, LAT);
                end
            end
            prev_ack = ack;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                vectors++;
                if (got >= 16 || out_data !== exp_q[got]) begin
                    miscompares++;
                    $display("FAIL stream_word[%0d]: got %h want %h", got, out_data, (got < 16) ? exp_q[got] : 8'hxx);
                end
                got++;
            end
            case (phase)
                0: if (idx < 16) begin set_word(DW'(idx), 1'b0); req = 1'b1; phase = 1; end
                1: if (ack) begin req = 1'b0; phase = 2; end
                default: if (!ack) begin idx++; phase = 0; end
            endcase
        end
        vectors++; if (got != 16 || idx != 16) begin
            miscompares++; $display("FAIL stream_count: got %0d delivered %0d sent want 16/16", got, idx);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w;
        int n;
        out_ready = 1'b1;
        w = DW'($urandom_range(0, 255));
        set_word(w, 1'b0);
        req = 1'b1;
        wait_ack(1'b1, 20, n);
        vectors++; if (ack !== 1'b1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL mid_in_ack: got ack=%b busy=%b want 1/1", ack, busy);
        end
        #2 rst = 1'b1;
        #1;
        vectors++; if (ack !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mid_async_clear: got ack=%b valid=%b busy=%b want 0/0/0", ack, out_valid, busy);
        end
        // req still high when reset releases: treated as a fresh transfer
        @(negedge clk);
        w = DW'($urandom_range(0, 255));
        set_word(w, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_ack(1'b1, 20, n);
        vectors++; if (n != LAT || out_data !== w || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL mid_new_xfer: got %0d edges data=%h valid=%b want %0d edges data=%h valid=1", n, out_data, out_valid, LAT, w);
        end
        req = 1'b0;
        wait_ack(1'b0, 20, n);
        vectors++; if (n != LAT) begin miscompares++; $display("FAIL mid_new_fall: got %0d edges want %0d", n, LAT); end
        @(negedge clk);
    endtask

`ifdef HS_RX_PARITY_EN
    task automatic test_parity();
        int   n;
        logic pre_ok;
        logic seen;
        out_ready = 1'b1;
        set_word(8'h03, 1'b0);
        par = 1'b1;
        req = 1'b1;
        pre_ok = 1'b1;
        n = 0;
        while (ack !== 1'b1 && n < 20) begin
            if (par_err !== 1'b0) pre_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        vectors++; if (!pre_ok) begin miscompares++; $display("FAIL par_early: par_err high before capture"); end
        vectors++; if (par_err !== 1'b1 || out_data !== 8'h03 || out_valid !== 1'b1) begin
            miscompares++; $display("FAIL par_flag: got par_err=%b data=%h valid=%b want 1/03/1", par_err, out_data, out_valid);
        end
        req = 1'b0;
        @(negedge clk);
        vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL par_pulse_len: got %b want 0", par_err); end
        wait_ack(1'b0, 20, n);
        @(negedge clk);
        set_word(8'h03, 1'b0);
        par  = 1'b0;
        req  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * LAT + 4; i++) begin
            @(negedge clk);
            if (par_err) seen = 1'b1;
            if (ack) req = 1'b0;
        end
        vectors++; if (seen) begin miscompares++; $display("FAIL par_clean: got par_err=1 want 0 for good parity"); end
        wait_ack(1'b0, 20, n);
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_reset_mid();
`ifdef HS_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
